// File: rtl/async_queue_sink_stage_if.sv
// -----------------------------------------------------------------------------
// async_queue_sink_stage_if
//   Dequeue handshake bundle between the sink half of the clock-crossing queue
//   and its downstream consumer.
//
//   Signals:
//     deq_valid  producer -> consumer  entry on deq_bits is valid
//     deq_ready  consumer -> producer  consumer accepts this cycle
//     deq_bits   producer -> consumer  payload, WIDTH bits
//
//   Modports:
//     master  the sink stage (drives valid/bits, samples ready)
//     slave   the consumer   (samples valid/bits, drives ready)
// -----------------------------------------------------------------------------
interface async_queue_sink_stage_if #(
    parameter int WIDTH = 32
);
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;

    modport master (
        output deq_valid,
        output deq_bits,
        input  deq_ready
    );

    modport slave (
        input  deq_valid,
        input  deq_bits,
        output deq_ready
    );
endinterface

// File: rtl/async_queue_sink_stage.sv
// -----------------------------------------------------------------------------
// async_queue_sink_stage
//   Sink-domain half of a clock-crossing queue. Runs entirely on the sink clock.
//   Synchronises the Gray write index from the source half, reads entries out
//   of the source-owned storage array, presents them on a registered
//   valid/ready dequeue port and returns its own Gray read index.
//
//   Parameters:
//     DEPTH_LOG2   log2 of queue entries (DEPTH = 2**DEPTH_LOG2)
//     WIDTH        payload bits per entry
//     SYNC_STAGES  flops in the write-index synchroniser, legal range 2..4
//
//   Ports:
//     clock        sink-domain clock
//     reset        synchronous, active-low reset
//     async_widx   Gray write index from the source domain (asynchronous)
//     async_mem    flattened source storage, entry i at [i*WIDTH +: WIDTH]
//     async_ridx   registered Gray read index back to the source domain
//     widx_err     sticky: synchronised write index moved by >1 Gray bit
//     deq          dequeue handshake (master side)
// -----------------------------------------------------------------------------
module async_queue_sink_stage #(
    parameter int DEPTH_LOG2  = 3,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DEPTH_LOG2:0]               async_widx,
    input  logic [WIDTH*(1<<DEPTH_LOG2)-1:0]  async_mem,
    output logic [DEPTH_LOG2:0]               async_ridx,
    output logic                              widx_err,
    async_queue_sink_stage_if.master          deq
);

    localparam logic [DEPTH_LOG2:0] IDX_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    // Write-index synchroniser; r_sync[SYNC_STAGES-1] is the usable widx_s.
    logic [DEPTH_LOG2:0] r_sync [SYNC_STAGES];
    logic [DEPTH_LOG2:0] r_prev_s;
    logic [DEPTH_LOG2:0] r_ridx_bin;
    logic [DEPTH_LOG2:0] r_ridx_gray;
    logic                r_deq_valid;
    logic [WIDTH-1:0]    r_deq_bits;
    logic                r_widx_err;

    logic [DEPTH_LOG2:0] w_widx_s;
    logic [DEPTH_LOG2:0] w_ridx_next;
    logic [DEPTH_LOG2:0] w_ridx_gray_next;
    logic [DEPTH_LOG2:0] w_widx_diff;
    logic                w_widx_jump;
    logic                w_nonempty;
    logic                w_pop;
    logic [WIDTH-1:0]    w_rd_data;

    assign w_widx_s = r_sync[SYNC_STAGES-1];

    // Empty/nonempty is decided purely in the Gray domain: the registered
    // Gray read index against the synchronised Gray write index.
    assign w_nonempty = (r_ridx_gray != w_widx_s);

    // Load the output register whenever it is empty or being drained.
    assign w_pop = w_nonempty & (~r_deq_valid | deq.deq_ready);

    assign w_ridx_next      = r_ridx_bin + IDX_ONE;
    assign w_ridx_gray_next = w_ridx_next ^ (w_ridx_next >> 1);

    // More than one bit set in the delta <=> clearing the lowest set bit
    // still leaves something behind.
    assign w_widx_diff = w_widx_s ^ r_prev_s;
    assign w_widx_jump = ((w_widx_diff & (w_widx_diff - IDX_ONE)) != '0);

    // The entry addressed by the low bits of the read index is only sampled
    // when w_pop says the synchronised write index covers it, so the source
    // guarantees it is stable at that point.
    assign w_rd_data = async_mem[int'(r_ridx_bin[DEPTH_LOG2-1:0]) * WIDTH +: WIDTH];

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev_s    <= '0;
            r_ridx_bin  <= '0;
            r_ridx_gray <= '0;
            r_deq_valid <= 1'b0;
            // NOTE: the payload register is reset too, so in-flight data is
            // discarded and never re-presented after a mid-stream reset.
            r_deq_bits  <= '0;
            r_widx_err  <= 1'b0;
        end else begin
            r_sync[0] <= async_widx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            // Error monitor only; it never feeds the datapath.
            r_prev_s <= w_widx_s;
            if (w_widx_jump) begin
                r_widx_err <= 1'b1;
            end

            if (w_pop) begin
                r_deq_bits  <= w_rd_data;
                r_deq_valid <= 1'b1;
                r_ridx_bin  <= w_ridx_next;
                // Source sees the read index advance on the same edge the
                // entry is captured into the output register.
                r_ridx_gray <= w_ridx_gray_next;
            end else if (r_deq_valid && deq.deq_ready) begin
                r_deq_valid <= 1'b0;
            end
        end
    end

    assign async_ridx    = r_ridx_gray;
    assign widx_err      = r_widx_err;
    assign deq.deq_valid = r_deq_valid;
    assign deq.deq_bits  = r_deq_bits;

endmodule

// File: tb/tb_async_queue_sink_stage.sv
// -----------------------------------------------------------------------------
// tb_async_queue_sink_stage
//   Bench for the sink half of the clock-crossing queue. A small source model
//   writes entries into the flattened storage and advances the Gray write
//   index one step at a time; every written payload is pushed to a scoreboard
//   queue, and a monitor pops and compares on each dequeue transfer.
// -----------------------------------------------------------------------------
module tb_async_queue_sink_stage;

    localparam int DEPTH_LOG2  = 3;
    localparam int WIDTH       = 32;
    localparam int SYNC_STAGES = 3;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic [DEPTH_LOG2:0]      async_widx;
    logic [WIDTH*DEPTH-1:0]   async_mem;
    logic [DEPTH_LOG2:0]      async_ridx;
    logic                     widx_err;

    async_queue_sink_stage_if #(.WIDTH(WIDTH)) deq_if ();

    async_queue_sink_stage #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .async_widx (async_widx),
        .async_mem  (async_mem),
        .async_ridx (async_ridx),
        .widx_err   (widx_err),
        .deq        (deq_if)
    );

    always #5 clock = ~clock;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] mon_exp;
    logic [3:0]       widx_bin;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] from_gray(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: a transfer happens at the next rising edge whenever
    // valid and ready are both high mid-cycle.
    always @(negedge clock) begin
        if (reset && deq_if.deq_valid && deq_if.deq_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got %h, required no beat", deq_if.deq_bits);
            end else begin
                mon_exp = exp_q.pop_front();
                if (deq_if.deq_bits !== mon_exp) begin
                    errors++;
                    $display("FAIL beat_data: got %h, required %h", deq_if.deq_bits, mon_exp);
                end
            end
        end
    end

    // Source model: write one entry and advance the write index by one Gray
    // step, waiting (bounded) while the queue is full.
    task automatic push_entry(input logic [WIDTH-1:0] data);
        int budget;
        budget = 0;
        while ((widx_bin - from_gray(async_ridx)) == 4'd8) begin
            if (budget == 100) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: queue full for %0d cycles, required drain", budget);
                return;
            end
            budget++;
            tick();
        end
        async_mem[int'(widx_bin[2:0]) * WIDTH +: WIDTH] = data;
        exp_q.push_back(data);
        widx_bin   = widx_bin + 4'd1;
        async_widx = to_gray(widx_bin);
    endtask

    task automatic do_reset();
        deq_if.deq_ready = 1'b0;
        reset            = 1'b0;
        async_widx       = '0;
        widx_bin         = '0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (deq_if.deq_bits !== 32'h0) begin
            errors++;
            $display("FAIL reset_bits: got %h, required 00000000", deq_if.deq_bits);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (deq_if.deq_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid cycle %0d: got %b, required 0", c, deq_if.deq_valid);
            end
            checks++;
            if (async_ridx !== 4'b0000) begin
                errors++;
                $display("FAIL idle_ridx cycle %0d: got %b, required 0000", c, async_ridx);
            end
            checks++;
            if (widx_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_err cycle %0d: got %b, required 0", c, widx_err);
            end
        end
    endtask

    task automatic test_latency();
        logic exp_valid;
        do_reset();
        deq_if.deq_ready = 1'b1;
        push_entry(32'hA5A5_0001);
        // Index sampled at edge N (c=1); output loads on edge N+3 (c=4).
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_valid = (c == 4);
            checks++;
            if (deq_if.deq_valid !== exp_valid) begin
                errors++;
                $display("FAIL latency_valid c=%0d: got %b, required %b", c, deq_if.deq_valid, exp_valid);
            end
            if (c == 4) begin
                checks++;
                if (deq_if.deq_bits !== 32'hA5A5_0001) begin
                    errors++;
                    $display("FAIL latency_bits: got %h, required a5a50001", deq_if.deq_bits);
                end
                checks++;
                if (async_ridx !== 4'b0001) begin
                    errors++;
                    $display("FAIL latency_ridx: got %b, required 0001", async_ridx);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] hist;
        hist = '0;
        do_reset();
        deq_if.deq_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) push_entry(32'hB0B0_0000 + c);
            tick();
            hist[c] = deq_if.deq_valid;
        end
        // Eight consecutive beats on samples 3..10.
        checks++;
        if (hist !== 16'h07F8) begin
            errors++;
            $display("FAIL b2b_valid_pattern: got %h, required 07f8", hist);
        end
        checks++;
        if (async_ridx !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_ridx: got %b, required 1100", async_ridx);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            push_entry(32'hC0DE_0000 + c);
            tick();
        end
        for (int s = 0; s < 5; s++) begin
            tick();
            checks++;
            if (deq_if.deq_valid !== 1'b1 || deq_if.deq_bits !== 32'hC0DE_0000) begin
                errors++;
                $display("FAIL stall_hold s=%0d: got v=%b %h, required v=1 c0de0000",
                         s, deq_if.deq_valid, deq_if.deq_bits);
            end
            checks++;
            if (async_ridx !== 4'b0001) begin
                errors++;
                $display("FAIL stall_ridx s=%0d: got %b, required 0001", s, async_ridx);
            end
        end
        deq_if.deq_ready = 1'b1;
        for (int b = 1; b <= 7; b++) begin
            tick();
            checks++;
            if (deq_if.deq_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_drain_valid beat %0d: got %b, required 1", b, deq_if.deq_valid);
            end
        end
        tick();
        checks++;
        if (deq_if.deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end_valid: got %b, required 0", deq_if.deq_valid);
        end
        checks++;
        if (async_ridx !== 4'b1100) begin
            errors++;
            $display("FAIL stall_end_ridx: got %b, required 1100", async_ridx);
        end
    endtask

    task automatic test_wrap();
        int budget;
        do_reset();
        deq_if.deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_entry(32'h1000_0000 + i);
            tick();
        end
        budget = 0;
        while ((exp_q.size() != 0 || deq_if.deq_valid) && budget < 50) begin
            budget++;
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || deq_if.deq_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: got %0d pending v=%b, required 0 pending v=0",
                     exp_q.size(), deq_if.deq_valid);
        end
        checks++;
        if (async_ridx !== 4'b0110) begin
            errors++;
            $display("FAIL wrap_ridx: got %b, required 0110", async_ridx);
        end
    endtask

    task automatic test_widx_err_reset();
        do_reset();
        async_mem[0 +: WIDTH]     = 32'hE000_0000;
        async_mem[WIDTH +: WIDTH] = 32'hE000_0001;
        exp_q.push_back(32'hE000_0000);
        exp_q.push_back(32'hE000_0001);
        widx_bin   = 4'd2;
        async_widx = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (widx_err !== 1'b0) begin
                errors++;
                $display("FAIL err_early c=%0d: got %b, required 0", c, widx_err);
            end
        end
        tick();
        checks++;
        if (deq_if.deq_valid !== 1'b1 || deq_if.deq_bits !== 32'hE000_0000) begin
            errors++;
            $display("FAIL err_pop: got v=%b %h, required v=1 e0000000", deq_if.deq_valid, deq_if.deq_bits);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (widx_err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky c=%0d: got %b, required 1", c, widx_err);
            end
            if (c < 3) tick();
        end
        // One-edge reset while an entry sits in the output register.
        reset      = 1'b0;
        async_widx = '0;
        widx_bin   = '0;
        exp_q.delete();
        tick();
        reset = 1'b1;
        checks++;
        if (deq_if.deq_valid !== 1'b0 || deq_if.deq_bits !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_deq: got v=%b %h, required v=0 00000000", deq_if.deq_valid, deq_if.deq_bits);
        end
        checks++;
        if (async_ridx !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_ridx: got %b, required 0000", async_ridx);
        end
        checks++;
        if (widx_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_err: got %b, required 0", widx_err);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (deq_if.deq_valid !== 1'b0 || widx_err !== 1'b0) begin
                errors++;
                $display("FAIL rst_after c=%0d: got v=%b err=%b, required 0 0", c, deq_if.deq_valid, widx_err);
            end
        end
    endtask

    initial begin
        deq_if.deq_ready = 1'b0;
        async_widx       = '0;
        async_mem        = '0;
        widx_bin         = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_widx_err_reset();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/async_queue_sink_stage.md
Name: async_queue_sink_stage

Overview:
- Sink-domain half of the clock-crossing queue. Runs entirely on the sink clock.
- Synchronises the Gray-coded write index arriving from the source half, and reads entries from the source-owned storage array.
- Presents entries on a registered valid/ready dequeue port and returns its own Gray-coded read index to the source half.
- Sits directly downstream of the source-side enqueue stage. Its dequeue port feeds the TileLink consumer watched by the crossing assertion monitor.

Parameters:
- DEPTH_LOG2, 3, log2 of queue entries (DEPTH = 2^DEPTH_LOG2).
- WIDTH, 32, payload bits per entry.
- SYNC_STAGES, 3, flops in the write-index synchroniser, legal range 2..4.

Ports:
- clock  input  1  sink-domain clock.
- reset  input  1  synchronous, active-low reset.
- async_widx  input  DEPTH_LOG2+1  Gray write index from the source domain (asynchronous).
- async_mem  input  WIDTH*DEPTH  flattened source storage; entry i occupies bits [i*WIDTH +: WIDTH].
- async_ridx  output  DEPTH_LOG2+1  Gray read index back to the source domain, registered.
- deq_valid  output  1  dequeue data valid.
- deq_ready  input  1  consumer accepts.
- deq_bits  output  WIDTH  dequeue payload.
- widx_err  output  1  sticky: synchronised write index moved by more than one Gray bit in a cycle.

Behaviour:
- One clock, synchronous active-low reset. Every flop updates only on the rising edge of clock.
- Reset values (reset==0 at an edge): synchroniser chain 0, ridx_bin 0, async_ridx 0, deq_valid 0, deq_bits 0, widx_err 0.
- Synchroniser: async_widx passes through SYNC_STAGES flops. The last stage is widx_s.
- ridx_bin: DEPTH_LOG2+1-bit binary counter. It wraps modulo 2^(DEPTH_LOG2+1); the extra MSB distinguishes full from empty at the source.
- ridx_gray = ridx_bin ^ (ridx_bin >> 1). async_ridx is the registered ridx_gray, updated on the same edge as ridx_bin.
- nonempty = (async_ridx != widx_s). Comparison is done in the Gray domain only.
- pop = nonempty & (~deq_valid | deq_ready).
- On pop:
  - deq_bits <= entry ridx_bin[DEPTH_LOG2-1:0] of async_mem.
  - deq_valid <= 1.
  - ridx_bin <= ridx_bin + 1.
- Else, if deq_valid & deq_ready: deq_valid <= 0. deq_bits holds.
- Otherwise all state holds. deq_bits never changes while deq_valid=1 and deq_ready=0.
- Handshake:
  - Transfer occurs when deq_valid & deq_ready at an edge.
  - deq_valid does not depend combinationally on deq_ready.
  - Throughput is 1 entry/cycle while nonempty and deq_ready held high.
- Latency: an async_widx increment sampled at edge N gives deq_valid=1 after edge N+SYNC_STAGES, with an empty queue and the output register empty.
- Return path: the source observes async_ridx advance on the same edge that deq_valid/deq_bits load.
- Storage read timing: async_mem entries are read only when the synchronised index shows them written. The source holds an entry stable until async_ridx passes it.
- Wrap-around: ridx_bin 4'b1111 -> 4'b0000 (DEPTH_LOG2=3). The next index read is entry 0.
- Empty with deq_ready high: deq_valid drops after the last transfer; no bubble data is produced.
- Full source: no special case here. The sink drains at its own rate.
- widx_err:
  - Let prev_s be widx_s registered once more.
  - Set when popcount(widx_s ^ prev_s) > 1.
  - Sticky until reset. It does not affect the datapath.
- Reset mid-operation:
  - All state returns to its reset value on the reset edge.
  - Any in-flight deq_bits is discarded.
  - The source half is reset together by the system, so indices realign at 0.

Test Plan:
- Reset, then async_widx held 0 for 10 cycles -> deq_valid=0, async_ridx=0, widx_err=0 throughout.
- async_mem entry0=32'hA5A5_0001, async_widx 0->1 (Gray 4'b0001) at edge N, deq_ready=1 -> deq_valid=1 with deq_bits=32'hA5A5_0001 after edge N+3. async_ridx=4'b0001 on the same edge. deq_valid=0 on the following edge.
- Fill all 8 entries (async_widx=Gray(8)=4'b1100), deq_ready=1 -> 8 consecutive valid beats in entry order. async_ridx ends at 4'b1100. deq_valid=0 on the 9th beat edge.
- Same fill with deq_ready=0 for 5 cycles, then 1 -> deq_bits holds entry0 while stalled. async_ridx stays 4'b0001 during the stall. Entries 1..7 drain back-to-back afterwards.
- Run 20 entries with continuous drain -> ridx_bin wraps 15->0. The 17th beat reads entry 0. Final async_ridx=Gray(20 mod 16)=4'b0110.
- Inject async_widx jump 4'b0000->4'b0011 -> widx_err=1 once the jump reaches widx_s, and it stays 1. Assert reset=0 for one edge while deq_valid=1 -> deq_valid=0, async_ridx=0, widx_err=0.
